// File: rtl/alu_share_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU op codes and the control FSM states.
package alu_share_pkg;

    localparam int OPND_W = 4;
    localparam int OP_W   = 3;
    localparam int RES_W  = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_NOT  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    // cand_idx[k] is the requester checked k-th, starting just after ptr
    logic [ID_W-1:0] cand_idx [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_W'((int'(ptr) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (en && !grant_valid && req[cand_idx[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU among NUM_REQ requesters; one op in flight,
// result returned on a single tagged valid/ready response channel.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_a,
    input  logic [4*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]  req_op,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [2:0]            alu_op,
    input  logic [7:0]            alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_result,
    output logic [ID_W-1:0]       rsp_id
);

    logic [OPND_W-1:0] req_a_arr  [NUM_REQ];
    logic [OPND_W-1:0] req_b_arr  [NUM_REQ];
    logic [OP_W-1:0]   req_op_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_a_arr[gi]  = req_a[OPND_W*gi +: OPND_W];
            assign req_b_arr[gi]  = req_b[OPND_W*gi +: OPND_W];
            assign req_op_arr[gi] = req_op[OP_W*gi +: OP_W];
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [OPND_W-1:0] a_reg, a_next;
    logic [OPND_W-1:0] b_reg, b_next;
    alu_op_t           op_reg, op_next;
    logic [ID_W-1:0]   g_reg, g_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [RES_W-1:0]  rsp_result_reg, rsp_result_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;

    logic              arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_valid;

    // Grants only in IDLE and never while reset is held, so no handshake can complete during reset
    assign arb_en = (state_reg == IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .en          (arb_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        op_next         = op_reg;
        g_next          = g_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_result_next = rsp_result_reg;
        rsp_id_next     = rsp_id_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    a_next     = req_a_arr[grant_idx];
                    b_next     = req_b_arr[grant_idx];
                    op_next    = alu_op_t'(req_op_arr[grant_idx]);
                    g_next     = grant_idx;
                    ptr_next   = grant_idx;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                rsp_result_next = alu_result;
                rsp_id_next     = g_reg;
                rsp_valid_next  = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= ID_W'(NUM_REQ - 1);
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= OP_ADD;
            g_reg          <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_id_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            op_reg         <= op_next;
            g_reg          <= g_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_result_reg <= rsp_result_next;
            rsp_id_reg     <= rsp_id_next;
        end
    end

    // ALU inputs only carry operands during EXEC; parked at zero otherwise
    assign alu_a  = (state_reg == EXEC) ? a_reg  : '0;
    assign alu_b  = (state_reg == EXEC) ? b_reg  : '0;
    assign alu_op = (state_reg == EXEC) ? op_reg : '0;

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_id     = rsp_id_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a 2-requester instance for directed/table tests and a
// 4-requester instance for the single-requester case and randomized scoreboard checking.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-requester instance
    logic [1:0] valid2, ready2;
    logic [7:0] a2, b2;
    logic [5:0] op2;
    logic [3:0] alu_a2, alu_b2;
    logic [2:0] alu_op2;
    logic [7:0] alu_res2;
    logic       rsp_valid2, rsp_ready2;
    logic [7:0] rsp_result2;
    logic       rsp_id2;

    // 4-requester instance
    logic [3:0]  valid4, ready4;
    logic [15:0] a4, b4;
    logic [11:0] op4;
    logic [3:0]  alu_a4, alu_b4;
    logic [2:0]  alu_op4;
    logic [7:0]  alu_res4;
    logic        rsp_valid4, rsp_ready4;
    logic [7:0]  rsp_result4;
    logic [1:0]  rsp_id4;

    int checks = 0;
    int errors = 0;

    // Reference ALU: 4-bit operands, 8-bit result
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return 8'(a) + 8'(b);
            3'd1:    return 8'(a) - 8'(b);
            3'd2:    return {4'h0, a & b};
            3'd3:    return {4'h0, a | b};
            3'd4:    return {4'h0, a ^ b};
            3'd5:    return {4'h0, ~(a & b)};
            3'd6:    return {4'h0, ~(a | b)};
            default: return {4'h0, ~a};
        endcase
    endfunction

    always_comb alu_res2 = alu_fn(alu_a2, alu_b2, alu_op2);
    always_comb alu_res4 = alu_fn(alu_a4, alu_b4, alu_op4);

    alu_share_arbiter #(.NUM_REQ(2), .ID_W(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(valid2), .req_ready(ready2),
        .req_a(a2), .req_b(b2), .req_op(op2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_result(alu_res2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_result(rsp_result2), .rsp_id(rsp_id2)
    );

    alu_share_arbiter #(.NUM_REQ(4), .ID_W(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(valid4), .req_ready(ready4),
        .req_a(a4), .req_b(b4), .req_op(op4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_res4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_result(rsp_result4), .rsp_id(rsp_id4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid2 = 2'b11;
        valid4 = 4'b0000;
        rsp_ready2 = 1'b0;
        rsp_ready4 = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rst_ready2", ready2, 0);
        chk("rst_rsp_valid2", rsp_valid2, 0);
        chk("rst_rsp_result2", rsp_result2, 0);
        chk("rst_rsp_id2", rsp_id2, 0);
        chk("rst_alu2", {alu_a2, alu_b2, alu_op2}, 0);
        chk("rst_rsp_valid4", rsp_valid4, 0);
        valid2 = 2'b00;
        next_cycle();
        rst = 1'b0;
    endtask

    // One single-requester transaction on the 2-requester instance; called at posedge+1
    task automatic txn2(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [7:0] exp, input int stall);
        int n;
        valid2 = 2'(1 << id);
        a2[4*id +: 4] = a;
        b2[4*id +: 4] = b;
        op2[3*id +: 3] = op;
        rsp_ready2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (ready2 == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("grant", ready2, 1 << id);
        next_cycle();
        valid2 = 2'b00;
        @(negedge clk);
        chk("exec_ready", ready2, 0);
        chk("exec_alu", {alu_a2, alu_b2, alu_op2}, {a, b, op});
        chk("exec_rsp_valid", rsp_valid2, 0);
        next_cycle();
        @(negedge clk);
        chk("rsp_valid", rsp_valid2, 1);
        chk("rsp_result", rsp_result2, exp);
        chk("rsp_id", rsp_id2, id);
        for (int s = 0; s < stall; s++) begin
            next_cycle();
            @(negedge clk);
            chk("stall_valid", rsp_valid2, 1);
            chk("stall_result", rsp_result2, exp);
        end
        next_cycle();
        rsp_ready2 = 1'b1;
        next_cycle();
        rsp_ready2 = 1'b0;
        @(negedge clk);
        chk("drain_valid", rsp_valid2, 0);
        chk("idle_alu", {alu_a2, alu_b2, alu_op2}, 0);
        next_cycle();
    endtask

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] exp;
        int         stall;
    } vec_t;

    vec_t vecs[10];

    // Scoreboard state for the randomized run on the 4-requester instance
    int         m_ptr;
    bit         m_pending;
    int         m_due;
    int         m_id;
    logic [7:0] m_res;

    function automatic int rr_pick(input int ptr, input logic [3:0] v, input int n);
        for (int k = 1; k <= n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid2 = '0; a2 = '0; b2 = '0; op2 = '0; rsp_ready2 = 1'b0;
        valid4 = '0; a4 = '0; b4 = '0; op4 = '0; rsp_ready4 = 1'b0;
        do_reset();

        // Directed table: basic add, full op sweep with a=C b=A, and a wrapping subtract
        vecs[0] = '{0, 4'h3, 4'h5, 3'd0, 8'h08, 0};
        vecs[1] = '{0, 4'hC, 4'hA, 3'd0, 8'h16, 0};
        vecs[2] = '{1, 4'hC, 4'hA, 3'd1, 8'h02, 1};
        vecs[3] = '{0, 4'hC, 4'hA, 3'd2, 8'h08, 2};
        vecs[4] = '{1, 4'hC, 4'hA, 3'd3, 8'h0E, 0};
        vecs[5] = '{0, 4'hC, 4'hA, 3'd4, 8'h06, 1};
        vecs[6] = '{1, 4'hC, 4'hA, 3'd5, 8'h07, 2};
        vecs[7] = '{0, 4'hC, 4'hA, 3'd6, 8'h01, 0};
        vecs[8] = '{1, 4'hC, 4'hA, 3'd7, 8'h03, 1};
        vecs[9] = '{1, 4'h3, 4'h5, 3'd1, 8'hFE, 0};
        for (int i = 0; i < 10; i++) begin
            $display("vector %0d: id=%0d a=%0h b=%0h op=%0d", i, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            txn2(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].stall);
        end

        // Response stalled 5 cycles while another requester waits
        do_reset();
        valid2 = 2'b01; a2 = 8'h1A; b2 = 8'h16; op2 = 6'b000_100;
        @(negedge clk);
        chk("t3_grant0", ready2, 2'b01);
        next_cycle();
        valid2 = 2'b10;
        @(negedge clk);
        chk("t3_exec_ready", ready2, 0);
        next_cycle();
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            chk("t3_stall_valid", rsp_valid2, 1);
            chk("t3_stall_result", rsp_result2, 8'h0C);
            chk("t3_stall_ready", ready2, 0);
            next_cycle();
        end
        rsp_ready2 = 1'b1;
        @(negedge clk);
        chk("t3_hs_ready", ready2, 0);
        chk("t3_hs_id", rsp_id2, 0);
        next_cycle();
        rsp_ready2 = 1'b0;
        @(negedge clk);
        chk("t3_grant1", ready2, 2'b10);
        chk("t3_idle_valid", rsp_valid2, 0);
        next_cycle();
        valid2 = 2'b00;
        next_cycle();
        @(negedge clk);
        chk("t3_rsp1_result", rsp_result2, 8'h02);
        chk("t3_rsp1_id", rsp_id2, 1);
        next_cycle();
        rsp_ready2 = 1'b1;
        next_cycle();
        rsp_ready2 = 1'b0;

        // Two requesters back to back: grants alternate every 3 cycles
        do_reset();
        a2 = 8'h91; b2 = 8'h42; op2 = 6'b011_000;
        valid2 = 2'b11;
        rsp_ready2 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t2_ready", ready2, (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 1 : 2) : 0);
            if (k % 3 == 2) begin
                chk("t2_rsp_valid", rsp_valid2, 1);
                chk("t2_rsp_id", rsp_id2, (k / 3) % 2);
                chk("t2_rsp_result", rsp_result2, ((k / 3) % 2 == 0) ? 8'h03 : 8'h0D);
            end else begin
                chk("t2_rsp_idle", rsp_valid2, 0);
            end
            next_cycle();
        end
        valid2 = 2'b00;
        rsp_ready2 = 1'b0;

        // Reset during RESP drops the response and restarts priority at requester 0
        do_reset();
        valid2 = 2'b01; a2 = 8'h11; b2 = 8'h11; op2 = 6'b0;
        @(negedge clk);
        chk("t4_grant", ready2, 2'b01);
        next_cycle();
        valid2 = 2'b00;
        next_cycle();
        @(negedge clk);
        chk("t4_resp_valid", rsp_valid2, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("t4_dropped", rsp_valid2, 0);
            next_cycle();
        end
        valid2 = 2'b11;
        @(negedge clk);
        chk("t4_next_grant", ready2, 2'b01);
        next_cycle();
        valid2 = 2'b00;
        do_reset();

        // Only requester 3 of 4 active: granted every IDLE visit
        a4 = 16'h5000; b4 = 16'h3000; op4 = 12'b001_000_000_000;
        valid4 = 4'b1000;
        rsp_ready4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t6_ready", ready4, (k % 3 == 0) ? 4'b1000 : 4'b0000);
            if (k % 3 == 2) begin
                chk("t6_rsp_id", rsp_id4, 3);
                chk("t6_rsp_result", rsp_result4, 8'h02);
            end
            next_cycle();
        end
        valid4 = 4'b0000;
        rsp_ready4 = 1'b0;

        // Randomized traffic on the 4-requester instance against the scoreboard
        do_reset();
        m_ptr = 3;
        m_pending = 1'b0;
        m_due = 0;
        m_id = 0;
        m_res = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int  g;
            bit  exp_rv;
            valid4 = 4'($urandom_range(0, 15));
            a4 = 16'($urandom);
            b4 = 16'($urandom);
            op4 = 12'($urandom);
            rsp_ready4 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_rv = m_pending && (cyc >= m_due);
            g = m_pending ? -1 : rr_pick(m_ptr, valid4, 4);
            chk("rnd_ready", ready4, (g >= 0) ? (1 << g) : 0);
            chk("rnd_rsp_valid", rsp_valid4, exp_rv);
            if (exp_rv) begin
                chk("rnd_rsp_result", rsp_result4, m_res);
                chk("rnd_rsp_id", rsp_id4, m_id);
            end
            if (exp_rv && rsp_ready4) begin
                $display("rnd response: cyc=%0d id=%0d result=%0h", cyc, m_id, m_res);
                m_pending = 1'b0;
            end
            if (g >= 0) begin
                m_pending = 1'b1;
                m_due = cyc + 2;
                m_id = g;
                m_res = alu_fn(a4[4*g +: 4], b4[4*g +: 4], op4[3*g +: 3]);
                m_ptr = g;
            end
            next_cycle();
        end
        valid4 = 4'b0000;
        rsp_ready4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
